// File: rtl/arrow_scroller_pkg.sv
// Shared constants and types for the arrow scroller: lane codes, judgement
// indicator codes, array geometry and the game FSM state encoding.
package arrow_scroller_pkg;

    localparam int NUM_STATES  = 26;
    localparam int CODE_W      = 3;
    localparam int NUM_BUTTONS = 5;
    localparam int IND_W       = 2;

    // Lane codes carried by the chart ROM and by every arrow_array slot.
    localparam logic [CODE_W-1:0] CODE_NONE  = 3'b000;
    localparam logic [CODE_W-1:0] CODE_UP    = 3'b001;
    localparam logic [CODE_W-1:0] CODE_LEFT  = 3'b010;
    localparam logic [CODE_W-1:0] CODE_DOWN  = 3'b011;
    localparam logic [CODE_W-1:0] CODE_RIGHT = 3'b100;
    localparam logic [CODE_W-1:0] CODE_BOLT  = 3'b110;
    localparam logic [CODE_W-1:0] CODE_END   = 3'b111;

    // Judgement indicator codes rendered by the pixel indexer.
    localparam logic [IND_W-1:0] IND_NONE      = 2'b00;
    localparam logic [IND_W-1:0] IND_BAD       = 2'b01;
    localparam logic [IND_W-1:0] IND_GOOD      = 2'b10;
    localparam logic [IND_W-1:0] IND_EXCELLENT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Button vector is {right,down,up,left,bolt}; map a bit index to its lane.
    function automatic logic [CODE_W-1:0] button_lane(input int idx);
        case (idx)
            0:       return CODE_BOLT;
            1:       return CODE_LEFT;
            2:       return CODE_UP;
            3:       return CODE_DOWN;
            4:       return CODE_RIGHT;
            default: return CODE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/arrow_scroller_lane_judge.sv
// Per-player judge: detects button presses, picks the lowest-index press,
// scores it against the two front slots, tracks which of those slots this
// player already hit, flags misses and holds the indicator for a few frames.
module arrow_scroller_lane_judge
    import arrow_scroller_pkg::*;
#(
    parameter int INDICATOR_HOLD = 30
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_active,
    input  logic                   i_clear,
    input  logic                   i_step,
    input  logic                   i_frame_tick,
    input  logic [NUM_BUTTONS-1:0] i_buttons,
    input  logic [CODE_W-1:0]      i_slot0,
    input  logic [CODE_W-1:0]      i_slot1,
    output logic [IND_W-1:0]       o_indicator
);

    localparam int HOLD_W = $clog2(INDICATOR_HOLD + 1);

    logic [NUM_BUTTONS-1:0] r_prev;
    logic                   r_hit0;
    logic                   r_hit1;
    logic [IND_W-1:0]       r_indicator;
    logic [HOLD_W-1:0]      r_hold;

    logic [NUM_BUTTONS-1:0] w_edges;
    logic                   w_press;
    logic [CODE_W-1:0]      w_lane;
    logic                   w_judge_valid;
    logic [IND_W-1:0]       w_judge_code;
    logic                   w_hit0_next;
    logic                   w_hit1_next;

    assign w_edges     = i_buttons & ~r_prev;
    assign o_indicator = r_indicator;

    // Pick the lowest-index rising edge; scanning downward lets it win last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_press = 1'b0;
        w_lane  = CODE_NONE;
        for (int b = NUM_BUTTONS - 1; b >= 0; b--) begin
            if (w_edges[b]) begin
                w_press = 1'b1;
                w_lane  = button_lane(b);
            end
        end
    end

    // Score a press against the pre-shift slots; a press outranks a miss.
    always_comb begin
        w_judge_valid = 1'b0;
        w_judge_code  = IND_NONE;
        w_hit0_next   = r_hit0;
        w_hit1_next   = r_hit1;
        if (i_active && w_press) begin
            w_judge_valid = 1'b1;
            if (i_slot0 == w_lane && !r_hit0) begin
                w_judge_code = IND_EXCELLENT;
                w_hit0_next  = 1'b1;
            end else if (i_slot1 == w_lane && !r_hit1) begin
                w_judge_code = IND_GOOD;
                w_hit1_next  = 1'b1;
            end else begin
                w_judge_code = IND_BAD;
            end
        end else if (i_active && i_step && i_slot0 != CODE_NONE && !r_hit0) begin
            w_judge_valid = 1'b1;
            w_judge_code  = IND_BAD;
        end
    end

    // Previous button sample for edge detection.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) r_prev <= '0;
        else       r_prev <= i_buttons;
    end

    // Hit mask follows the array: on a step slot1's flag moves to slot0.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_hit0 <= 1'b0;
            r_hit1 <= 1'b0;
        end else if (i_step) begin
            r_hit0 <= w_hit1_next;
            r_hit1 <= 1'b0;
        end else begin
            r_hit0 <= w_hit0_next;
            r_hit1 <= w_hit1_next;
        end
    end

    // Indicator with frame-based hold timer; blank outside active play.
    always_ff @(posedge clock) begin
        if (reset || !i_active) begin
            r_indicator <= IND_NONE;
            r_hold      <= '0;
        end else if (w_judge_valid) begin
            r_indicator <= w_judge_code;
            r_hold      <= HOLD_W'(INDICATOR_HOLD);
        end else if (i_frame_tick && r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
            if (r_hold == HOLD_W'(1)) r_indicator <= IND_NONE;
        end
    end

endmodule

// File: rtl/arrow_scroller.sv
// Game-state stage ahead of the VGA pixel indexer: song FSM, frame divider,
// chart ROM addressing, the scrolling arrow array and two player judges.
module arrow_scroller
    import arrow_scroller_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 4,
    parameter int CHART_ADDR_W    = 8,
    parameter int INDICATOR_HOLD  = 30
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         start,
    output logic [CHART_ADDR_W-1:0]      chart_addr,
    input  logic [CODE_W-1:0]            chart_data,
    input  logic [NUM_BUTTONS-1:0]       p1_buttons,
    input  logic [NUM_BUTTONS-1:0]       p2_buttons,
    output logic [NUM_STATES*CODE_W-1:0] arrow_array,
    output logic [IND_W-1:0]             p1_indicator,
    output logic [IND_W-1:0]             p2_indicator,
    output logic                         song_done
);

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int DC_W = $clog2(NUM_STATES);
    localparam int AW   = NUM_STATES * CODE_W;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [FC_W-1:0]         r_frame_cnt;
    logic [DC_W-1:0]         r_drain_cnt;
    logic [CHART_ADDR_W-1:0] r_chart_addr;
    logic [AW-1:0]           r_array;

    logic                    w_active;
    logic                    w_step;
    logic                    w_start_song;
    logic                    w_end_code;
    logic                    w_drain_last;
    logic [CODE_W-1:0]       w_new_top;

    assign w_active     = (r_state == ST_PLAY) || (r_state == ST_DRAIN);
    assign w_step       = w_active && frame_tick
                          && (r_frame_cnt == FC_W'(FRAMES_PER_STEP - 1));
    assign w_start_song = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_end_code   = (chart_data == CODE_END);
    assign w_drain_last = (r_drain_cnt == DC_W'(NUM_STATES - 1));
    // The end marker is never stored; draining feeds blanks.
    assign w_new_top    = (r_state == ST_PLAY && !w_end_code) ? chart_data : CODE_NONE;

    assign chart_addr  = r_chart_addr;
    assign arrow_array = r_array;
    assign song_done   = (r_state == ST_DONE);

    // Song FSM state register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Song FSM next-state logic; start only matters in IDLE and DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE,
            ST_DONE:  if (start) w_next_state = ST_PLAY;
            ST_PLAY:  if (w_step && w_end_code) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_step && w_drain_last) w_next_state = ST_DONE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Frame divider: one scroll step every FRAMES_PER_STEP frame ticks.
    always_ff @(posedge clock) begin
        if (reset || !w_active) begin
            r_frame_cnt <= '0;
        end else if (frame_tick) begin
            if (r_frame_cnt == FC_W'(FRAMES_PER_STEP - 1)) r_frame_cnt <= '0;
            else                                           r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // Count drain steps until the last chart arrow has left slot 0.
    always_ff @(posedge clock) begin
        if (reset || r_state != ST_DRAIN) r_drain_cnt <= '0;
        else if (w_step)                  r_drain_cnt <= r_drain_cnt + 1'b1;
    end

    // Chart ROM address advances once per step while reading the chart.
    always_ff @(posedge clock) begin
        if (reset || w_start_song)          r_chart_addr <= '0;
        else if (w_step && r_state == ST_PLAY) r_chart_addr <= r_chart_addr + 1'b1;
    end

    // Scrolling array: slot i takes slot i+1, the top slot takes the new code.
    always_ff @(posedge clock) begin
        // NOTE: the array is plain flops shifted in parallel, not a RAM, so it
        // is reset like any other state; the renderer must see blanks.
        if (reset || w_start_song) r_array <= '0;
        else if (w_step)           r_array <= {w_new_top, r_array[AW-1:CODE_W]};
    end

    arrow_scroller_lane_judge #(.INDICATOR_HOLD(INDICATOR_HOLD)) u_judge_p1 (
        .clock        (clock),
        .reset        (reset),
        .i_active     (w_active),
        .i_clear      (w_start_song),
        .i_step       (w_step),
        .i_frame_tick (frame_tick),
        .i_buttons    (p1_buttons),
        .i_slot0      (r_array[CODE_W-1:0]),
        .i_slot1      (r_array[2*CODE_W-1:CODE_W]),
        .o_indicator  (p1_indicator)
    );

    arrow_scroller_lane_judge #(.INDICATOR_HOLD(INDICATOR_HOLD)) u_judge_p2 (
        .clock        (clock),
        .reset        (reset),
        .i_active     (w_active),
        .i_clear      (w_start_song),
        .i_step       (w_step),
        .i_frame_tick (frame_tick),
        .i_buttons    (p2_buttons),
        .i_slot0      (r_array[CODE_W-1:0]),
        .i_slot1      (r_array[2*CODE_W-1:CODE_W]),
        .o_indicator  (p2_indicator)
    );

endmodule
